// File: rtl/usb_in_pkg.sv
// usb_in_pkg: shared types and helpers for the USB IN packet FIFO (in_fifo_pkt).
package usb_in_pkg;

  // Packet FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  // Legal full-speed/high-speed IN endpoint packet sizes.
  typedef enum int {
    MPS_8  = 8,
    MPS_16 = 16,
    MPS_32 = 32,
    MPS_64 = 64
  } mps_e;

  // Ceil-log2 usable in constant expressions; clog2(1) == 0.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/in_fifo_pkt_mem.sv
// in_fifo_pkt_mem: DEPTH x 8 byte store, one synchronous write port and an
// asynchronous read port so the SIE sees the current byte without latency.
module in_fifo_pkt_mem
  import usb_in_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Byte write; the array is deliberately left out of reset.
  // NOTE: data storage has no reset -- validity is tracked by the pointers,
  // and a reset on the array would turn it into flops plus a wide reset net.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/in_fifo_pkt.sv
// in_fifo_pkt: USB IN byte FIFO with packet snapshot, ACK commit and retry
// rewind. Three pointers: wr (next free), rd (next to send), cm (oldest unacked).
// Optional build macro IN_FIFO_PKT_LEVEL_EN adds app_in_level_o and
// app_in_almost_full_o.
module in_fifo_pkt
  import usb_in_pkg::*;
#(
  parameter  int DEPTH           = 64,
  parameter  int MAX_PACKET_SIZE = MPS_8,
  localparam int PTR_W           = clog2(DEPTH),
  localparam int LEN_W           = clog2(MAX_PACKET_SIZE + 1)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             clk_gate_i,
  input  logic [7:0]       app_in_data_i,
  input  logic             app_in_valid_i,
  output logic             app_in_ready_o,
  input  logic             in_req_i,
  output logic [LEN_W-1:0] in_len_o,
  output logic [7:0]       in_data_o,
  output logic             in_valid_o,
  input  logic             in_ready_i,
  output logic             in_last_o,
  input  logic             in_ack_i,
  input  logic             in_retry_i,
`ifdef IN_FIFO_PKT_LEVEL_EN
  output logic [PTR_W:0]   app_in_level_o,
  output logic             app_in_almost_full_o,
`endif
  output logic             app_in_buffer_empty_o
);

  localparam int PW = PTR_W + 1;

  state_e           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    cm_ptr_q, cm_ptr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] left_q, left_d;

  logic [PW-1:0]    occupancy;
  logic [PW-1:0]    unsent;
  logic [LEN_W-1:0] snap_len;
  logic             wr_en;
  logic [7:0]       rd_data;

  // Pointer arithmetic wraps modulo 2*DEPTH, so plain subtraction gives counts.
  assign occupancy      = wr_ptr_q - cm_ptr_q;
  assign unsent         = wr_ptr_q - rd_ptr_q;
  assign snap_len       = (unsent > PW'(MAX_PACKET_SIZE)) ? LEN_W'(MAX_PACKET_SIZE)
                                                          : LEN_W'(unsent);
  assign app_in_ready_o = (occupancy != PW'(DEPTH));
  assign wr_en          = app_in_valid_i && app_in_ready_o;

  assign app_in_buffer_empty_o = (wr_ptr_q == cm_ptr_q);

`ifdef IN_FIFO_PKT_LEVEL_EN
  assign app_in_level_o       = occupancy;
  assign app_in_almost_full_o = (occupancy >= PW'(DEPTH - MAX_PACKET_SIZE));
`endif

  in_fifo_pkt_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[PTR_W-1:0]),
    .wdata_i (app_in_data_i),
    .raddr_i (rd_ptr_q[PTR_W-1:0]),
    .rdata_o (rd_data)
  );

  // Only a live byte is presented; idle output reads as zero.
  assign in_data_o = in_valid_o ? rd_data : 8'h00;

  // Next-state logic for the packet FSM, read/commit pointers and lengths.
  // NOTE: every output of this block is defaulted first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q + PW'(wr_en);
    rd_ptr_d   = rd_ptr_q;
    cm_ptr_d   = cm_ptr_q;
    len_d      = len_q;
    left_d     = left_q;
    in_valid_o = 1'b0;
    in_last_o  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Snapshot uses pre-write pointers: a same-cycle write is excluded.
        if (clk_gate_i && in_req_i) begin
          len_d   = snap_len;
          left_d  = snap_len;
          state_d = (snap_len == '0) ? WAIT_ACK : SEND;
        end
      end

      SEND: begin
        in_valid_o = 1'b1;
        in_last_o  = (left_q == LEN_W'(1));
        if (clk_gate_i && in_retry_i && !in_ack_i) begin
          // Abort mid-packet: rewind to the oldest unacked byte.
          rd_ptr_d = cm_ptr_q;
          state_d  = IDLE;
        end else if (clk_gate_i && in_ready_i) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          left_d   = left_q - LEN_W'(1);
          if (left_q == LEN_W'(1)) state_d = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        if (clk_gate_i && in_ack_i) begin
          cm_ptr_d = rd_ptr_q;
          state_d  = IDLE;
        end else if (clk_gate_i && in_retry_i) begin
          rd_ptr_d = cm_ptr_q;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and pointer registers with synchronous active-low reset.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cm_ptr_q <= '0;
      len_q    <= '0;
      left_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cm_ptr_q <= cm_ptr_d;
      len_q    <= len_d;
      left_q   <= left_d;
    end
  end

  assign in_len_o = len_q;

endmodule

// File: tb/tb_in_fifo_pkt.sv
// tb_in_fifo_pkt: self-checking bench for in_fifo_pkt (DEPTH=64, MPS=8).
// The reference model is a byte queue of uncommitted data plus a count of
// bytes already sent from its head in the current packet.
module tb_in_fifo_pkt;

  localparam int DEPTH = 64;
  localparam int MPS   = 8;
  localparam int LEN_W = 4;

  logic             clk_i = 1'b0;
  logic             reset_n_i;
  logic             clk_gate_i;
  logic [7:0]       app_in_data_i;
  logic             app_in_valid_i;
  logic             app_in_ready_o;
  logic             in_req_i;
  logic [LEN_W-1:0] in_len_o;
  logic [7:0]       in_data_o;
  logic             in_valid_o;
  logic             in_ready_i;
  logic             in_last_o;
  logic             in_ack_i;
  logic             in_retry_i;
  logic             app_in_buffer_empty_o;
`ifdef IN_FIFO_PKT_LEVEL_EN
  logic [6:0]       app_in_level_o;
  logic             app_in_almost_full_o;
`endif

  in_fifo_pkt #(
    .DEPTH           (DEPTH),
    .MAX_PACKET_SIZE (MPS)
  ) dut (
    .clk_i                 (clk_i),
    .reset_n_i             (reset_n_i),
    .clk_gate_i            (clk_gate_i),
    .app_in_data_i         (app_in_data_i),
    .app_in_valid_i        (app_in_valid_i),
    .app_in_ready_o        (app_in_ready_o),
    .in_req_i              (in_req_i),
    .in_len_o              (in_len_o),
    .in_data_o             (in_data_o),
    .in_valid_o            (in_valid_o),
    .in_ready_i            (in_ready_i),
    .in_last_o             (in_last_o),
    .in_ack_i              (in_ack_i),
    .in_retry_i            (in_retry_i),
`ifdef IN_FIFO_PKT_LEVEL_EN
    .app_in_level_o        (app_in_level_o),
    .app_in_almost_full_o  (app_in_almost_full_o),
`endif
    .app_in_buffer_empty_o (app_in_buffer_empty_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [7:0] model_q[$];
  int         sent;
  int         cur_len;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Offer one byte; the model decides whether it must be accepted.
  task automatic write_byte(input logic [7:0] b);
    logic exp_ready;
    exp_ready      = (model_q.size() != DEPTH);
    app_in_data_i  = b;
    app_in_valid_i = 1'b1;
    #1;
    checks++;
    if (app_in_ready_o !== exp_ready) begin
      errors++;
      $display("FAIL app_ready: got %b expected %b (stored %0d)", app_in_ready_o, exp_ready, model_q.size());
    end
    step();
    app_in_valid_i = 1'b0;
    if (exp_ready) model_q.push_back(b);
  endtask

  task automatic do_request();
    int exp_len;
    exp_len = model_q.size() - sent;
    if (exp_len > MPS) exp_len = MPS;
    in_req_i = 1'b1;
    step();
    in_req_i = 1'b0;
    cur_len  = exp_len;
    checks++;
    if (in_len_o !== LEN_W'(exp_len)) begin
      errors++;
      $display("FAIL in_len: got %0d expected %0d", in_len_o, exp_len);
    end
    checks++;
    if (in_valid_o !== (exp_len != 0)) begin
      errors++;
      $display("FAIL req_valid: got %b expected %b", in_valid_o, exp_len != 0);
    end
  endtask

  // Consume n bytes of the current packet, optionally with gated-off stalls.
  task automatic do_send(input int n, input bit stall);
    for (int i = 0; i < n; i++) begin
      if (stall && ($urandom_range(0, 2) == 0)) begin
        clk_gate_i = 1'b0;
        in_ready_i = 1'b1;
        step();
        in_ready_i = 1'b0;
        clk_gate_i = 1'b1;
      end
      checks++;
      if (in_valid_o !== 1'b1 || in_data_o !== model_q[sent] || in_last_o !== (sent == cur_len - 1)) begin
        errors++;
        $display("FAIL send_byte[%0d]: got valid=%b data=%h last=%b expected valid=1 data=%h last=%b",
                 sent, in_valid_o, in_data_o, in_last_o, model_q[sent], sent == cur_len - 1);
      end
      in_ready_i = 1'b1;
      step();
      in_ready_i = 1'b0;
      sent++;
    end
    if (sent == cur_len) begin
      checks++;
      if (in_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL post_send_valid: got %b expected 0", in_valid_o);
      end
    end
  endtask

  task automatic do_ack(input bit with_retry);
    in_ack_i   = 1'b1;
    in_retry_i = with_retry;
    step();
    in_ack_i   = 1'b0;
    in_retry_i = 1'b0;
    for (int i = 0; i < sent; i++) void'(model_q.pop_front());
    sent = 0;
    checks++;
    if (app_in_buffer_empty_o !== (model_q.size() == 0) || app_in_ready_o !== (model_q.size() != DEPTH)) begin
      errors++;
      $display("FAIL ack_state: got empty=%b ready=%b expected empty=%b ready=%b",
               app_in_buffer_empty_o, app_in_ready_o, model_q.size() == 0, model_q.size() != DEPTH);
    end
  endtask

  task automatic do_retry();
    in_retry_i = 1'b1;
    step();
    in_retry_i = 1'b0;
    sent = 0;
    checks++;
    if (in_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL retry_valid: got %b expected 0", in_valid_o);
    end
  endtask

  task automatic test_reset();
    in_req_i       = 1'b0;
    in_ready_i     = 1'b0;
    in_ack_i       = 1'b0;
    in_retry_i     = 1'b0;
    app_in_valid_i = 1'b0;
    clk_gate_i     = 1'b1;
    reset_n_i      = 1'b0;
    step();
    step();
    reset_n_i = 1'b1;
    model_q.delete();
    sent    = 0;
    cur_len = 0;
    checks++;
    if (app_in_ready_o !== 1'b1 || app_in_buffer_empty_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_app: got ready=%b empty=%b expected 1 1", app_in_ready_o, app_in_buffer_empty_o);
    end
    checks++;
    if (in_valid_o !== 1'b0 || in_last_o !== 1'b0 || in_len_o !== '0 || in_data_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_sie: got valid=%b last=%b len=%0d data=%h expected 0 0 0 00",
               in_valid_o, in_last_o, in_len_o, in_data_o);
    end
`ifdef IN_FIFO_PKT_LEVEL_EN
    checks++;
    if (app_in_level_o !== '0 || app_in_almost_full_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_level: got level=%0d af=%b expected 0 0", app_in_level_o, app_in_almost_full_o);
    end
`endif
  endtask

  task automatic test_basic();
    for (int i = 0; i < 5; i++) write_byte(8'h10 + 8'(i));
    do_request();
    checks++;
    if (in_len_o !== 4'd5) begin
      errors++;
      $display("FAIL basic_len: got %0d expected 5", in_len_o);
    end
    do_send(5, 1'b0);
    do_ack(1'b0);
  endtask

  task automatic test_multi_packet();
    for (int i = 0; i < 20; i++) write_byte(8'($urandom));
    for (int r = 0; r < 3; r++) begin
      do_request();
      do_send(cur_len, 1'b0);
      do_ack(1'b0);
    end
    do_request();  // zero-length packet
    step();
    checks++;
    if (in_valid_o !== 1'b0 || in_len_o !== '0) begin
      errors++;
      $display("FAIL zlp: got valid=%b len=%0d expected 0 0", in_valid_o, in_len_o);
    end
    do_ack(1'b0);
  endtask

  task automatic test_retry();
    for (int i = 0; i < 8; i++) write_byte(8'($urandom));
    do_request();
    do_send(8, 1'b0);
    do_retry();
    for (int i = 0; i < 2; i++) write_byte(8'($urandom));
    do_request();
    do_send(cur_len, 1'b0);
    do_ack(1'b0);
    do_request();
    do_send(cur_len, 1'b0);
    do_ack(1'b0);
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) write_byte(8'($urandom));
    write_byte(8'hEE);  // refused: buffer full
    do_request();
    do_send(cur_len, 1'b0);
    do_ack(1'b0);       // checks ready returns the cycle after ACK
    for (int i = 0; i < 8; i++) write_byte(8'($urandom));
    write_byte(8'hDD);  // refused again
    for (int r = 0; r < 10 && model_q.size() > 0; r++) begin
      do_request();
      do_send(cur_len, 1'b0);
      do_ack(1'b0);
    end
  endtask

  task automatic test_gate();
    for (int i = 0; i < 3; i++) write_byte(8'($urandom));
    clk_gate_i = 1'b0;
    in_req_i   = 1'b1;
    in_ack_i   = 1'b1;
    write_byte(8'($urandom));  // app side is not gated
    in_req_i = 1'b0;
    in_ack_i = 1'b0;
    checks++;
    if (in_valid_o !== 1'b0 || in_len_o !== '0) begin
      errors++;
      $display("FAIL gated_req: got valid=%b len=%0d expected 0 0", in_valid_o, in_len_o);
    end
    clk_gate_i = 1'b1;
    do_request();
    clk_gate_i = 1'b0;
    in_ready_i = 1'b1;
    step();
    in_ready_i = 1'b0;
    checks++;
    if (in_valid_o !== 1'b1 || in_data_o !== model_q[0]) begin
      errors++;
      $display("FAIL gated_ready: got valid=%b data=%h expected 1 %h", in_valid_o, in_data_o, model_q[0]);
    end
    clk_gate_i = 1'b1;
    do_send(cur_len, 1'b0);
    clk_gate_i = 1'b0;
    in_ack_i   = 1'b1;
    step();
    in_ack_i   = 1'b0;
    clk_gate_i = 1'b1;
    checks++;
    if (app_in_buffer_empty_o !== 1'b0) begin
      errors++;
      $display("FAIL gated_ack: got empty=%b expected 0", app_in_buffer_empty_o);
    end
    do_ack(1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) write_byte(8'($urandom));
    do_request();
    do_send(3, 1'b0);
    test_reset();
  endtask

  task automatic test_random();
    int n;
    int k;
    int choice;
    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) write_byte(8'($urandom));
      do_request();
      if (cur_len == 0) begin
        if ($urandom_range(0, 1) == 0) do_ack(1'b0);
        else do_retry();
      end else begin
        k = $urandom_range(1, cur_len);
        do_send(k, 1'b1);
        if (k < cur_len) begin
          do_retry();
        end else begin
          choice = $urandom_range(0, 2);
          if (choice == 0) do_ack(1'b0);
          else if (choice == 1) do_retry();
          else do_ack(1'b1);  // ACK wins over simultaneous retry
        end
      end
    end
    for (int r = 0; r < 12 && model_q.size() > 0; r++) begin
      do_request();
      do_send(cur_len, 1'b0);
      do_ack(1'b0);
    end
  endtask

  initial begin
    reset_n_i      = 1'b0;
    clk_gate_i     = 1'b1;
    app_in_data_i  = 8'h00;
    app_in_valid_i = 1'b0;
    in_req_i       = 1'b0;
    in_ready_i     = 1'b0;
    in_ack_i       = 1'b0;
    in_retry_i     = 1'b0;
    sent           = 0;
    cur_len        = 0;

    test_reset();
    test_basic();
    test_multi_packet();
    test_retry();
    test_full();
    test_reset();
    test_gate();
    test_reset_mid();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
